// File: rtl/add_responder.sv
// Responder side of the en/ack adder handshake: queues requests and returns a+b with an ack pulse.
// Optional drop counter port drop_cnt is enabled by defining ADD_RESP_DROP_CNT_EN.
module add_responder #(
   parameter int DW      = 8,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   input  logic            en,
   output logic [2*DW-1:0] out,
   output logic            ack,
   output logic            busy,
   output logic            full,
   output logic            drop,
   output logic [1:0]      dbg_state
`ifdef ADD_RESP_DROP_CNT_EN
   ,
   output logic [7:0]      drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   // Handshake: a request is a rising edge of en seen at posedge; each accepted
   // request yields exactly one single-cycle ack, with out updated in that same cycle.
   state_t            r_state;
   state_t            w_state_next;
   logic              r_en_q;
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic [2*DW-1:0]   r_mem [DEPTH];
   logic [DW-1:0]     r_op_a;
   logic [DW-1:0]     r_op_b;
   logic [CW-1:0]     r_cnt;
   logic [2*DW-1:0]   r_out;
   logic              r_ack;
   logic              r_drop;

   logic              w_push;
   logic              w_full;
   logic              w_empty;
   logic              w_wr_en;
   logic              w_pop;
   logic              w_calc_done;
   logic [2*DW-1:0]   w_head;

   assign w_push  = en & ~r_en_q;
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   // Fullness is taken from the registered pointers, so a same-edge pop cannot rescue a push.
   assign w_wr_en = w_push & ~w_full;
   assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_calc_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_state_next = ST_CALC;
            end
         end
         ST_CALC: begin
            if (r_cnt == '0) begin
               w_calc_done  = 1'b1;
               w_state_next = ST_ACK;
            end
         end
         ST_ACK:  w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {a, b};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_en_q   <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_cnt    <= '0;
         r_out    <= '0;
         r_ack    <= 1'b0;
         r_drop   <= 1'b0;
      end else begin
         r_en_q <= en;
         r_drop <= w_push & w_full;
         r_ack  <= w_calc_done;
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            r_op_a   <= w_head[2*DW-1:DW];
            r_op_b   <= w_head[DW-1:0];
            r_cnt    <= CW'(LATENCY - 1);
         end else if (r_state == ST_CALC && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_calc_done) begin
            r_out <= (2*DW)'(r_op_a) + (2*DW)'(r_op_b);
         end
      end
   end

`ifdef ADD_RESP_DROP_CNT_EN
   logic [7:0] r_drop_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_drop_cnt <= '0;
      end else if (w_push && w_full && r_drop_cnt != 8'hFF) begin
         r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

   assign out       = r_out;
   assign ack       = r_ack;
   assign busy      = (r_state != ST_IDLE) || !w_empty;
   assign full      = w_full;
   assign drop      = r_drop;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_add_responder.sv
// Self-checking bench for add_responder: occupancy model feeds an expected-result queue,
// a negedge monitor checks every ack against it, and scenario tasks check timing inline.
module tb_add_responder;

   localparam int DW      = 8;
   localparam int LATENCY = 2;
   localparam int DEPTH   = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [DW-1:0]   a = '0;
   logic [DW-1:0]   b = '0;
   logic            en = 1'b0;
   logic [2*DW-1:0] out;
   logic            ack;
   logic            busy;
   logic            full;
   logic            drop;
   logic [1:0]      dbg_state;
`ifdef ADD_RESP_DROP_CNT_EN
   logic [7:0]      drop_cnt;
`endif

   always #5 clk = ~clk;

   add_responder #(.DW(DW), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .b         (b),
      .en        (en),
      .out       (out),
      .ack       (ack),
      .busy      (busy),
      .full      (full),
      .drop      (drop),
      .dbg_state (dbg_state)
`ifdef ADD_RESP_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;
   logic [2*DW-1:0] exp_q[$];

   // Transaction-level model of the responder: queue occupancy plus the edge at
   // which the server can next take a request (one result per LATENCY+2 edges).
   int   m_edge;
   int   m_cnt;
   int   m_free;
   int   m_drops;
   logic m_en_q;

   int   ack_seen  = 0;
   int   drop_seen = 0;
   logic full_seen = 1'b0;
   logic prev_ack  = 1'b0;
   logic [2*DW-1:0] mon_exp;

   always @(negedge clk) begin
      if (reset) begin
         if (ack) begin
            ack_seen++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_ack: got ack with out=%0d, required no ack", out);
            end else begin
               mon_exp = exp_q.pop_front();
               if (out !== mon_exp) begin
                  bad++;
                  $display("FAIL ack_out: got %0d required %0d", out, mon_exp);
               end
            end
            total++;
            if (prev_ack !== 1'b0) begin
               bad++;
               $display("FAIL ack_width: ack high two cycles running, required one");
            end
         end
         if (drop) drop_seen++;
         if (full) full_seen = 1'b1;
         prev_ack = ack;
      end else begin
         prev_ack = 1'b0;
      end
   end

   task automatic model_reset();
      exp_q.delete();
      m_edge  = 0;
      m_cnt   = 0;
      m_free  = 0;
      m_drops = 0;
      m_en_q  = 1'b0;
   endtask

   // Called just after a negedge; applies inputs for the next posedge and returns
   // 1ns after the following negedge so the monitor has already run.
   task automatic drive_cycle(input logic e, input logic [DW-1:0] av, input logic [DW-1:0] bv);
      logic push;
      logic pop;
      en = e;
      a  = av;
      b  = bv;
      push = e && !m_en_q;
      pop  = (m_edge >= m_free) && (m_cnt > 0);
      if (push && m_cnt == DEPTH) begin
         m_drops++;
      end else if (push) begin
         exp_q.push_back((2*DW)'(av) + (2*DW)'(bv));
         m_cnt++;
      end
      if (pop) begin
         m_cnt--;
         m_free = m_edge + LATENCY + 2;
      end
      m_en_q = e;
      m_edge++;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive_cycle(1'b0, DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)));
      end
   endtask

   task automatic test_reset();
      en    = 1'b0;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         total++; if (out !== '0)   begin bad++; $display("FAIL reset_out: got %0d required 0", out); end
         total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b required 0", ack); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
         total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b required 0", full); end
         total++; if (drop !== 1'b0) begin bad++; $display("FAIL reset_drop: got %b required 0", drop); end
      end
      reset = 1'b1;
   endtask

   task automatic test_hold_en();
      int a0;
      a0 = ack_seen;
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'd7, 8'd1);
      idle(10);
      total++; if (ack_seen - a0 !== 1) begin bad++; $display("FAIL hold_en_acks: got %0d required 1", ack_seen - a0); end
      total++; if (out !== 16'd8) begin bad++; $display("FAIL hold_en_out: got %0d required 8", out); end
   endtask

   task automatic test_max_operands();
      int a0;
      a0 = ack_seen;
      drive_cycle(1'b1, 8'd255, 8'd255);
      idle(8);
      total++; if (ack_seen - a0 !== 1) begin bad++; $display("FAIL max_acks: got %0d required 1", ack_seen - a0); end
      total++; if (out !== 16'h01FE) begin bad++; $display("FAIL max_out: got %h required 01fe", out); end
   endtask

   task automatic test_latency();
      logic [DW-1:0]   av;
      logic [DW-1:0]   bv;
      logic [2*DW-1:0] s;
      av = DW'($urandom_range(0, 255));
      bv = DW'($urandom_range(0, 255));
      s  = (2*DW)'(av) + (2*DW)'(bv);
      drive_cycle(1'b1, av, bv);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL lat_n0_ack: got %b required 0", ack); end
      idle(1);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL lat_n1_ack: got %b required 0", ack); end
      idle(1);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL lat_n2_ack: got %b required 0", ack); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL lat_n2_busy: got %b required 1", busy); end
      idle(1);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL lat_n3_ack: got %b required 1", ack); end
      total++; if (out !== s) begin bad++; $display("FAIL lat_n3_out: got %0d required %0d", out, s); end
      idle(1);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL lat_n4_ack: got %b required 0", ack); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL lat_n4_busy: got %b required 0", busy); end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && n < 200) begin
         idle(1);
         n++;
      end
      total++;
      if (n >= 200) begin
         bad++;
         $display("FAIL %s_drain: %0d results still pending after 200 cycles, required 0", name, exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int a0;
      int d0;
      int md0;
      a0  = ack_seen;
      d0  = drop_seen;
      md0 = m_drops;
      full_seen = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         drive_cycle(1'b1, DW'(k), DW'(k));
         drive_cycle(1'b0, DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)));
      end
      drain("b2b");
      total++; if (full_seen !== 1'b1) begin bad++; $display("FAIL b2b_full_seen: got %b required 1", full_seen); end
      total++; if (drop_seen == d0) begin bad++; $display("FAIL b2b_any_drop: got 0 drops required at least 1"); end
      total++;
      if (drop_seen - d0 !== m_drops - md0) begin
         bad++;
         $display("FAIL b2b_drops: got %0d required %0d", drop_seen - d0, m_drops - md0);
      end
      total++;
      if (ack_seen - a0 !== 12 - (m_drops - md0)) begin
         bad++;
         $display("FAIL b2b_acks: got %0d required %0d", ack_seen - a0, 12 - (m_drops - md0));
      end
`ifdef ADD_RESP_DROP_CNT_EN
      total++;
      if (drop_cnt !== 8'(m_drops)) begin
         bad++;
         $display("FAIL b2b_drop_cnt: got %0d required %0d", drop_cnt, m_drops);
      end
`endif
   endtask

   task automatic test_reset_mid_calc();
      int a0;
      drive_cycle(1'b1, 8'd71, 8'd23);
      idle(1);
      #2;
      reset = 1'b0;
      #1;
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL rst_calc_ack: got %b required 0", ack); end
      total++; if (out !== '0)   begin bad++; $display("FAIL rst_calc_out: got %0d required 0", out); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_calc_busy: got %b required 0", busy); end
      en = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      reset = 1'b1;
      a0 = ack_seen;
      idle(6);
      total++; if (ack_seen !== a0) begin bad++; $display("FAIL rst_calc_late_ack: got %0d acks required 0", ack_seen - a0); end
      total++; if (out !== '0) begin bad++; $display("FAIL rst_calc_out_hold: got %0d required 0", out); end
      drive_cycle(1'b1, 8'd14, 8'd11);
      idle(8);
      drain("rst_calc");
      total++; if (out !== 16'd25) begin bad++; $display("FAIL rst_calc_after: got %0d required 25", out); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      @(negedge clk);
      #1;
      test_reset();
      idle(2);
      test_hold_en();
      test_max_operands();
      test_latency();
      idle(4);
      test_back_to_back();
      test_reset_mid_calc();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL final_queue: got %0d pending results required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
